// File: rtl/noc_pkg.sv
// Shared NoC constants: port indices, flit coordinate fields and the XY routing function.
package noc_pkg;

  localparam int NUM_PORTS  = 5;
  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  localparam int COORD_W = 4;
  localparam int X_LSB   = 4;
  localparam int Y_LSB   = 0;

  typedef logic [NUM_PORTS-1:0] route_t;
  typedef logic [COORD_W-1:0]   coord_t;

  // X is resolved first, then Y; a flit already at its destination goes local.
  function automatic route_t xy_route(input coord_t dest_x, input coord_t dest_y,
                                      input coord_t here_x, input coord_t here_y);
    route_t r;
    r = '0;
    if (dest_x > here_x)      r[PORT_EAST]  = 1'b1;
    else if (dest_x < here_x) r[PORT_WEST]  = 1'b1;
    else if (dest_y > here_y) r[PORT_NORTH] = 1'b1;
    else if (dest_y < here_y) r[PORT_SOUTH] = 1'b1;
    else                      r[PORT_LOCAL] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous FIFO for flit+route entries; exposes the head and the entry behind it.
module flit_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic         single,
  output logic [W-1:0] head,
  output logic [W-1:0] head_next
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  rd_ptr_inc;
  logic [AW:0]  fill;

  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign fill       = wr_ptr - rd_ptr;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign single = (fill == {{AW{1'b0}}, 1'b1});

  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_next = mem[rd_ptr_inc[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/input_requester.sv
// Router input port: buffers flits, routes at push, requests the output arbiter for the head.
// Optional sticky protocol-error output enabled by defining INPUT_REQUESTER_ERR_EN.
//
// state   | meaning
// IDLE    | FIFO empty, all requests low
// REQUEST | head valid, one-hot request for the head's output port held until granted
module input_requester
  import noc_pkg::*;
#(
  parameter int FLIT_W  = 32,
  parameter int DEPTH   = 4,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              req0,
  output logic              req1,
  output logic              req2,
  output logic              req3,
  output logic              req4,
  input  logic              gnt0,
  input  logic              gnt1,
  input  logic              gnt2,
  input  logic              gnt3,
  input  logic              gnt4,
  output logic [FLIT_W-1:0] out_flit
`ifdef INPUT_REQUESTER_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int EW = FLIT_W + NUM_PORTS;
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_REQUEST = 1'b1;
  localparam coord_t HERE_X = coord_t'(LOCAL_X);
  localparam coord_t HERE_Y = coord_t'(LOCAL_Y);

  logic [0:0]  state;
  route_t      req_q;
  route_t      gnt;
  route_t      in_route;
  logic        rdy_q;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        single;
  logic [EW-1:0] wdata;
  logic [EW-1:0] head;
  logic [EW-1:0] head_next;
  logic [EW-1:0] nxt_entry;
  logic          nxt_valid;

  assign gnt = {gnt4, gnt3, gnt2, gnt1, gnt0};
  assign {req4, req3, req2, req1, req0} = req_q;

  assign in_route = xy_route(in_flit[X_LSB +: COORD_W], in_flit[Y_LSB +: COORD_W], HERE_X, HERE_Y);
  assign wdata    = {in_route, in_flit};

  // rdy_q holds in_ready low for the first cycle after reset release.
  assign in_ready = rdy_q && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_REQUEST) && |(gnt & req_q);

  flit_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (wdata),
    .full      (full),
    .empty     (empty),
    .single    (single),
    .head      (head),
    .head_next (head_next)
  );

  // Head as it will be after this edge, so req/out_flit can be registered with no bubble.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_entry = head;
    if (pop) begin
      if (!single) begin
        nxt_valid = 1'b1;
        nxt_entry = head_next;
      end else if (push) begin
        nxt_valid = 1'b1;
        nxt_entry = wdata;
      end
    end else if (!empty) begin
      nxt_valid = 1'b1;
      nxt_entry = head;
    end else if (push) begin
      nxt_valid = 1'b1;
      nxt_entry = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      out_flit <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      state <= nxt_valid ? ST_REQUEST : ST_IDLE;
      req_q <= nxt_valid ? nxt_entry[FLIT_W +: NUM_PORTS] : '0;
      if (nxt_valid) out_flit <= nxt_entry[FLIT_W-1:0];
    end
  end

`ifdef INPUT_REQUESTER_ERR_EN
  logic err_q;
  logic bad_gnt;

  assign bad_gnt = (|(gnt & ~req_q)) || ($countones(gnt) > 1);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (!rst)         err_q <= 1'b0;
    else if (bad_gnt) err_q <= 1'b1;
  end
`endif

endmodule
